io_arbiter: RTL and testbench

IO_ARBITER -- requirements
Module: io_arbiter

---
 rtl/io_pkg.sv | 16 +
 rtl/io_arbiter_if.sv | 49 ++++
 rtl/io_arbiter_rr_arb2.sv | 34 +++
 rtl/io_arbiter.sv | 107 ++++++++++
 tb/tb_io_arbiter.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared types and default widths for the two-master IO arbiter.
package io_pkg;

  localparam int IO_ADDR_W = 8;
  localparam int IO_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RDATA = 2'd2
  } state_t;

  localparam logic [1:0] GRANT_M0 = 2'b01;
  localparam logic [1:0] GRANT_M1 = 2'b10;

endpackage

// File: rtl/io_arbiter_if.sv
// rtl/io_arbiter_if.sv - master command/response signals and shared peripheral bus.
interface io_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic [ADDR_W-1:0] io_address;
  logic [DATA_W-1:0] io_din;
  logic              io_w_en;
  logic              io_r_en;
  logic [DATA_W-1:0] io_dout;

  // Arbiter side.
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    input  m1_req, m1_we, m1_addr, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output io_address, io_din, io_w_en, io_r_en,
    input  io_dout
  );

  // Masters plus peripheral side.
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    output m1_req, m1_we, m1_addr, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  io_address, io_din, io_w_en, io_r_en,
    output io_dout
  );

endinterface

// File: rtl/io_arbiter_rr_arb2.sv
// rtl/io_arbiter_rr_arb2.sv - two-way winner select with last-granted pointer.
module rr_arb2
  import io_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       rr_en,
  input  logic       update,
  output logic [1:0] grant
);

  // 1 means m1 was granted last, so m0 wins the next tie.
  logic last_m1;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = GRANT_M0;
      2'b10:   grant = GRANT_M1;
      2'b11:   grant = (rr_en && !last_m1) ? GRANT_M1 : GRANT_M0;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_m1 <= 1'b1;
    end else if (update && (grant != 2'b00)) begin
      last_m1 <= grant[1];
    end
  end

endmodule

// File: rtl/io_arbiter.sv
// rtl/io_arbiter.sv - arbitrates two masters onto one IO bus; one access in flight at a time.
module io_arbiter
  import io_pkg::*;
#(
  parameter int ADDR_W = IO_ADDR_W,
  parameter int DATA_W = IO_DATA_W,
  parameter int RR_EN  = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  io_arbiter_if.slave  bus
);

  state_t            state;
  state_t            state_nxt;
  logic [1:0]        req;
  logic [1:0]        grant;
  logic              arb_update;
  logic              win_m1;
  logic              cmd_we;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  // Requests only count while idle; ISSUE and RDATA ignore them.
  assign req        = {bus.m1_req, bus.m0_req};
  assign arb_update = (state == ST_IDLE) && (req != 2'b00);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .rr_en  (RR_EN != 0),
    .update (arb_update),
    .grant  (grant)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req != 2'b00) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = cmd_we ? ST_IDLE : ST_RDATA;
      ST_RDATA: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_m1    <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (arb_update) begin
      win_m1    <= grant[1];
      cmd_we    <= grant[1] ? bus.m1_we    : bus.m0_we;
      cmd_addr  <= grant[1] ? bus.m1_addr  : bus.m0_addr;
      cmd_wdata <= grant[1] ? bus.m1_wdata : bus.m0_wdata;
    end
  end

  // io_dout is valid during RDATA; capture it and pulse rvalid the cycle after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rvalid_q <= {(state == ST_RDATA) && win_m1, (state == ST_RDATA) && !win_m1};
      if ((state == ST_RDATA) && !win_m1) rdata0_q <= bus.io_dout;
      if ((state == ST_RDATA) && win_m1)  rdata1_q <= bus.io_dout;
    end
  end

  always_comb begin
    bus.io_address = '0;
    bus.io_din     = '0;
    bus.io_w_en    = 1'b0;
    bus.io_r_en    = 1'b0;
    bus.m0_gnt     = 1'b0;
    bus.m1_gnt     = 1'b0;
    if (state == ST_ISSUE) begin
      bus.io_address = cmd_addr;
      bus.io_din     = cmd_wdata;
      bus.io_w_en    = cmd_we;
      bus.io_r_en    = !cmd_we;
      bus.m0_gnt     = !win_m1;
      bus.m1_gnt     = win_m1;
    end
  end

  assign bus.m0_rvalid = rvalid_q[0];
  assign bus.m1_rvalid = rvalid_q[1];
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_io_arbiter.sv
// tb/tb_io_arbiter.sv - self-checking bench for io_arbiter (round-robin and fixed-priority builds).
module tb_io_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_arbiter_if #(.ADDR_W(8), .DATA_W(8)) a ();
  io_arbiter_if #(.ADDR_W(8), .DATA_W(8)) b ();

  io_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(1)) dut_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a.slave)
  );

  io_arbiter #(.ADDR_W(8), .DATA_W(8), .RR_EN(0)) dut_fp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  typedef struct {
    int         m;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
  } gexp_t;

  typedef struct {
    int         m;
    logic [7:0] data;
  } rexp_t;

  typedef struct {
    int         m;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  gexp_t      gq[$];
  rexp_t      rq[$];
  logic [7:0] last_rd [2];
  logic [7:0] mem [256];
  logic       prev_w = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Registered peripheral: read data appears the cycle after io_r_en.
  always @(posedge clk) begin
    if (a.io_w_en) mem[a.io_address] <= a.io_din;
    if (a.io_r_en) a.io_dout <= mem[a.io_address];
  end

  // Scoreboard monitor on the round-robin instance.
  always @(negedge clk) begin : mon
    logic [1:0] g;
    logic [1:0] rv;
    gexp_t      e;
    rexp_t      r;
    g  = {a.m1_gnt, a.m0_gnt};
    rv = {a.m1_rvalid, a.m0_rvalid};
    if (g == 2'b00) begin
      chk("bus_zero_outside_issue", {a.io_w_en, a.io_r_en, a.io_address, a.io_din}, 0);
    end else begin
      chk("gnt_not_both", g == 2'b11, 0);
      chk("gnt_expected", gq.size() > 0, 1);
      if (gq.size() > 0) begin
        e = gq.pop_front();
        chk("gnt_master", g, (e.m == 1) ? 2'b10 : 2'b01);
        chk("io_w_en", a.io_w_en, e.we);
        chk("io_r_en", a.io_r_en, !e.we);
        chk("io_address", a.io_address, e.addr);
        if (e.we) chk("io_din", a.io_din, e.wdata);
      end
    end
    chk("w_en_not_consecutive", prev_w && a.io_w_en, 0);
    prev_w = a.io_w_en;
    if (rv != 2'b00) begin
      chk("rvalid_not_both", rv == 2'b11, 0);
      chk("rvalid_expected", rq.size() > 0, 1);
      if (rq.size() > 0) begin
        r = rq.pop_front();
        chk("rvalid_master", rv, (r.m == 1) ? 2'b10 : 2'b01);
        chk("rdata", (r.m == 1) ? a.m1_rdata : a.m0_rdata, r.data);
      end
    end
  end

  task automatic set_m(input int m, input logic req, input logic we,
                       input logic [7:0] addr, input logic [7:0] wdata);
    if (m == 0) begin
      a.m0_req = req; a.m0_we = we; a.m0_addr = addr; a.m0_wdata = wdata;
    end else begin
      a.m1_req = req; a.m1_we = we; a.m1_addr = addr; a.m1_wdata = wdata;
    end
  endtask

  task automatic access(input vec_t v);
    int n;
    @(negedge clk);
    set_m(v.m, 1'b1, v.we, v.addr, v.wdata);
    gq.push_back('{v.m, v.we, v.addr, v.wdata});
    if (!v.we) rq.push_back('{v.m, v.rd});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((v.m == 0) ? a.m0_gnt : a.m1_gnt) && n < 10);
    chk("gnt_latency", n, 1);
    set_m(v.m, 1'b0, 1'b0, 8'h00, 8'h00);
    if (!v.we) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!((v.m == 0) ? a.m0_rvalid : a.m1_rvalid) && n < 10);
      chk("rvalid_latency", n, 2);
      last_rd[v.m] = v.rd;
      chk("other_rdata_hold", (v.m == 0) ? a.m1_rdata : a.m0_rdata, last_rd[1 - v.m]);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rdata"}, {a.m0_rdata, a.m1_rdata, b.m0_rdata, b.m1_rdata}, 0);
    chk({tag, "_a_ctl"}, {a.m0_gnt, a.m0_rvalid, a.m1_gnt, a.m1_rvalid,
                          a.io_address, a.io_din, a.io_w_en, a.io_r_en}, 0);
    chk({tag, "_b_ctl"}, {b.m0_gnt, b.m0_rvalid, b.m1_gnt, b.m1_rvalid,
                          b.io_address, b.io_din, b.io_w_en, b.io_r_en}, 0);
  endtask

  initial begin
    vec_t vecs [6];
    int   fp_exp [4];
    int   got[$];
    int   gc [3];
    int   n;
    int   k;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h02] = 8'h3C;
    a.io_dout = 8'h00;
    b.io_dout = 8'h00;
    set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_m(1, 1'b0, 1'b0, 8'h00, 8'h00);
    b.m0_req = 1'b0; b.m0_we = 1'b0; b.m0_addr = 8'h00; b.m0_wdata = 8'h00;
    b.m1_req = 1'b0; b.m1_we = 1'b0; b.m1_addr = 8'h00; b.m1_wdata = 8'h00;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;

    vecs[0] = '{0, 1'b1, 8'h01, 8'hA5, 8'h00};
    vecs[1] = '{1, 1'b0, 8'h02, 8'h00, 8'h3C};
    vecs[2] = '{0, 1'b0, 8'h01, 8'h00, 8'hA5};
    vecs[3] = '{1, 1'b1, 8'h10, 8'h77, 8'h00};
    vecs[4] = '{0, 1'b0, 8'h10, 8'h00, 8'h77};
    vecs[5] = '{1, 1'b0, 8'hFF, 8'h00, 8'hA5};
    fp_exp  = '{0, 0, 0, 1};

    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) access(vecs[i]);

    // Round-robin with both masters requesting continuously.
    @(negedge clk);
    set_m(0, 1'b1, 1'b1, 8'h20, 8'h11);
    set_m(1, 1'b1, 1'b1, 8'h21, 8'h22);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) gq.push_back('{0, 1'b1, 8'h20, 8'h11});
      else            gq.push_back('{1, 1'b1, 8'h21, 8'h22});
    end
    k = 0; n = 0;
    while (k < 4 && n < 20) begin
      @(negedge clk);
      n++;
      if (a.m0_gnt || a.m1_gnt) k++;
    end
    set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_m(1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("rr_grant_count", k, 4);

    // Fixed priority: m0 keeps winning until it drops its request.
    @(negedge clk);
    b.m0_req = 1'b1; b.m0_we = 1'b1; b.m0_addr = 8'h30; b.m0_wdata = 8'h01;
    b.m1_req = 1'b1; b.m1_we = 1'b1; b.m1_addr = 8'h31; b.m1_wdata = 8'h02;
    n = 0;
    while (got.size() < 4 && n < 30) begin
      @(negedge clk);
      n++;
      chk("fp_gnt_not_both", b.m0_gnt && b.m1_gnt, 0);
      if (b.m0_gnt) begin
        got.push_back(0);
        if (got.size() == 3) b.m0_req = 1'b0;
      end
      if (b.m1_gnt) begin
        got.push_back(1);
        b.m1_req = 1'b0;
      end
    end
    b.m0_req = 1'b0;
    b.m1_req = 1'b0;
    chk("fp_grant_count", got.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < got.size()) chk($sformatf("fp_order_%0d", i), got[i], fp_exp[i]);
    end

    // Back-to-back writes from m0 with req held high.
    @(negedge clk);
    set_m(0, 1'b1, 1'b1, 8'h50, 8'h99);
    for (int i = 0; i < 3; i++) gq.push_back('{0, 1'b1, 8'h50, 8'h99});
    k = 0; n = 0;
    while (k < 3 && n < 20) begin
      @(negedge clk);
      n++;
      if (a.m0_gnt) begin
        gc[k] = n;
        k++;
        if (k == 3) set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
      end
    end
    set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("b2b_count", k, 3);
    if (k == 3) begin
      chk("b2b_gap_1", gc[1] - gc[0], 2);
      chk("b2b_gap_2", gc[2] - gc[1], 2);
    end

    // Reset asserted while a read sits in RDATA.
    @(negedge clk);
    set_m(1, 1'b1, 1'b0, 8'h02, 8'h00);
    gq.push_back('{1, 1'b0, 8'h02, 8'h00});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!a.m1_gnt && n < 10);
    chk("rst_read_gnt_latency", n, 1);
    set_m(1, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_in_rdata");
    @(negedge clk);
    rst_n = 1'b1;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_no_rvalid", {a.m0_rvalid, a.m1_rvalid}, 0);
    end
    set_m(0, 1'b1, 1'b1, 8'h40, 8'h0A);
    set_m(1, 1'b1, 1'b1, 8'h41, 8'h0B);
    gq.push_back('{0, 1'b1, 8'h40, 8'h0A});
    gq.push_back('{1, 1'b1, 8'h41, 8'h0B});
    k = 0; n = 0;
    while (k < 2 && n < 20) begin
      @(negedge clk);
      n++;
      if (a.m0_gnt || a.m1_gnt) k++;
    end
    set_m(0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_m(1, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("post_reset_grant_count", k, 2);

    repeat (4) @(negedge clk);
    chk("gnt_queue_drained", gq.size(), 0);
    chk("rvalid_queue_drained", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
